// File: rtl/prepare_eng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prepare_eng_pkg
// Purpose  : Shared types, constants and helpers for the prepare-engine
//            realigner (state encoding, byte/word sizing, word counting).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package prepare_eng_pkg;

    // Default bus geometry; the realigner is parameterised and only uses
    // these as parameter defaults.
    localparam int c_BYTE_W       = 8;
    localparam int c_DEF_DATA_W   = 512;
    localparam int c_DEF_B        = c_DEF_DATA_W / c_BYTE_W;
    localparam int c_DEF_SHIFT_W  = $clog2(c_DEF_B);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } realign_state_e;

    // ceil(nbytes / 2**lg_bytes). Bytes-per-word is a power of two, so the
    // divide reduces to an add and a shift.
    function automatic logic [31:0] words_ceil(input logic [31:0] nbytes,
                                               input int unsigned lg_bytes);
        return (nbytes + ((32'd1 << lg_bytes) - 32'd1)) >> lg_bytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prepare_eng_realign_shifter.sv
`default_nettype none
// ============================================================================
// Module   : prepare_eng_realign_shifter
// Purpose  : Combinational byte funnel shifter. Produces bytes [shift..B-1]
//            of the hold word followed by bytes [0..shift-1] of the input
//            word. Byte 0 sits in the most significant byte lane.
// Ports    : i_hold  - previously accepted word
//            i_data  - current input word (zero for a drain beat)
//            i_shift - leading bytes dropped from the hold word
//            o_data  - realigned output word
// Revision : 1.0 - initial release
// ============================================================================
module prepare_eng_realign_shifter
    import prepare_eng_pkg::*;
#(
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int SHIFT_W = $clog2(DATA_W / c_BYTE_W)
) (
    input  logic [DATA_W-1:0]  i_hold,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [DATA_W-1:0]  o_data
);

    // One extra bit so the input shift amount can reach DATA_W, which
    // shifts the whole input word out when i_shift is zero.
    localparam int c_AMT_W = $clog2(DATA_W) + 1;

    logic [c_AMT_W-1:0] w_hold_amt;
    logic [c_AMT_W-1:0] w_data_amt;

    assign w_hold_amt = c_AMT_W'(i_shift) << 3;
    assign w_data_amt = c_AMT_W'(DATA_W) - w_hold_amt;
    assign o_data     = (i_hold << w_hold_amt) | (i_data >> w_data_amt);

endmodule
`default_nettype wire

// File: rtl/prepare_eng_log_realign.sv
`default_nettype none
// ============================================================================
// Module   : prepare_eng_log_realign
// Purpose  : Strips a per-request leading byte offset from the payload
//            stream and re-packs the payload into bus-aligned beats for the
//            log controller (payload byte 0 in lane 0 of the first beat).
// Ports    : clk, rst_n                 - clock, async active-low reset
//            src_realign_cmd_*          - command (shift, len) handshake
//            src_realign_data*          - input word stream + last
//            realign_src_*_rdy          - command / input ready
//            realign_log_ctrl_rd_*      - output beat, last, pad bytes
//            log_ctrl_realign_rd_rdy    - output ready
//            realign_len_err            - sticky input-last mismatch flag
// Config   : PREP_REALIGN_ZERO_PAD_EN - zero the pad bytes of the last beat
// Revision : 1.0 - initial release
// ============================================================================
module prepare_eng_log_realign
    import prepare_eng_pkg::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int LEN_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            src_realign_cmd_val,
    input  logic [$clog2(DATA_W/8)-1:0]     src_realign_cmd_shift,
    input  logic [LEN_W-1:0]                src_realign_cmd_len,
    output logic                            realign_src_cmd_rdy,
    input  logic                            src_realign_data_val,
    input  logic [DATA_W-1:0]               src_realign_data,
    input  logic                            src_realign_data_last,
    output logic                            realign_src_data_rdy,
    output logic                            realign_log_ctrl_rd_val,
    output logic [DATA_W-1:0]               realign_log_ctrl_rd_data,
    output logic                            realign_log_ctrl_rd_last,
    output logic [$clog2(DATA_W/8)-1:0]     realign_log_ctrl_rd_padbytes,
    input  logic                            log_ctrl_realign_rd_rdy,
    output logic                            realign_len_err
);

    localparam int c_B       = DATA_W / c_BYTE_W;
    localparam int c_SHIFT_W = $clog2(c_B);
    localparam int c_CNT_W   = LEN_W + 1;

    realign_state_e         r_state;
    logic [c_SHIFT_W-1:0]   r_shift;
    logic [c_SHIFT_W-1:0]   r_pad;
    logic [c_CNT_W-1:0]     r_in_left;
    logic [c_CNT_W-1:0]     r_out_left;
    logic [DATA_W-1:0]      r_hold;
    logic                   r_len_err;

    logic                   w_pass;
    logic                   w_in_acc;
    logic                   w_out_xfer;
    logic                   w_last;
    logic                   w_in_last_exp;
    logic [c_CNT_W-1:0]     w_tot_bytes;
    logic [c_CNT_W-1:0]     w_in_words;
    logic [c_CNT_W-1:0]     w_out_words;
    logic [c_SHIFT_W-1:0]   w_pad;
    logic [DATA_W-1:0]      w_shift_in;
    logic [DATA_W-1:0]      w_shift_out;
    logic [DATA_W-1:0]      w_data;

    // ------------------------------------------------------------------
    // Command decode (only registered on accept, so cmd_val never reaches
    // an output combinationally)
    // ------------------------------------------------------------------
    assign w_tot_bytes = c_CNT_W'(src_realign_cmd_len) + c_CNT_W'(src_realign_cmd_shift);
    assign w_in_words  = c_CNT_W'(words_ceil(32'(w_tot_bytes), c_SHIFT_W));
    assign w_out_words = c_CNT_W'(words_ceil(32'(src_realign_cmd_len), c_SHIFT_W));
    // (B - len%B) % B is the two's complement of len modulo B.
    assign w_pad       = c_SHIFT_W'(0) - src_realign_cmd_len[c_SHIFT_W-1:0];

    assign w_pass        = (r_shift == '0);
    assign w_in_last_exp = (r_in_left == c_CNT_W'(1));

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    always_comb begin
        realign_src_cmd_rdy     = (r_state == ST_IDLE);
        realign_src_data_rdy    = 1'b0;
        realign_log_ctrl_rd_val = 1'b0;
        w_last                  = 1'b0;
        unique case (r_state)
            ST_FIRST: begin
                // Shifted mode primes the hold register without emitting.
                realign_src_data_rdy = !w_pass;
            end
            ST_STREAM: begin
                // Both modes consume exactly one input per output beat.
                realign_log_ctrl_rd_val = src_realign_data_val;
                realign_src_data_rdy    = log_ctrl_realign_rd_rdy;
                w_last                  = (r_out_left == c_CNT_W'(1));
            end
            ST_DRAIN: begin
                realign_log_ctrl_rd_val = 1'b1;
                w_last                  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_in_acc   = src_realign_data_val && realign_src_data_rdy;
    assign w_out_xfer = realign_log_ctrl_rd_val && log_ctrl_realign_rd_rdy;

    assign realign_log_ctrl_rd_last     = w_last;
    assign realign_log_ctrl_rd_padbytes = w_last ? r_pad : '0;
    assign realign_len_err              = r_len_err;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // The drain beat has no input word behind it; feed zeros so the tail
    // of the hold word comes out zero-extended.
    assign w_shift_in = (r_state == ST_DRAIN) ? '0 : src_realign_data;

    prepare_eng_realign_shifter #(
        .DATA_W  (DATA_W),
        .SHIFT_W (c_SHIFT_W)
    ) u_shifter (
        .i_hold  (r_hold),
        .i_data  (w_shift_in),
        .i_shift (r_shift),
        .o_data  (w_shift_out)
    );

    assign w_data = (w_pass && (r_state == ST_STREAM)) ? src_realign_data : w_shift_out;

`ifdef PREP_REALIGN_ZERO_PAD_EN
    always_comb begin
        realign_log_ctrl_rd_data = w_data;
        if (w_last) begin
            for (int i = 0; i < c_B; i++) begin
                if (i >= (c_B - int'(r_pad))) begin
                    realign_log_ctrl_rd_data[DATA_W-1-8*i -: 8] = 8'h00;
                end
            end
        end
    end
`else
    assign realign_log_ctrl_rd_data = w_data;
`endif

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_pad      <= '0;
            r_in_left  <= '0;
            r_out_left <= '0;
            r_len_err  <= 1'b0;
        end else begin
            // Input last is only cross-checked; the counters end requests.
            if (w_in_acc && (src_realign_data_last != w_in_last_exp)) begin
                r_len_err <= 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (src_realign_cmd_val) begin
                        r_shift    <= src_realign_cmd_shift;
                        r_pad      <= w_pad;
                        r_in_left  <= w_in_words;
                        r_out_left <= w_out_words;
                        if (src_realign_cmd_len != '0) begin
                            r_state <= ST_FIRST;
                        end
                    end
                end
                ST_FIRST: begin
                    if (w_pass) begin
                        r_state <= ST_STREAM;
                    end else if (w_in_acc) begin
                        r_in_left <= r_in_left - c_CNT_W'(1);
                        r_state   <= w_in_last_exp ? ST_DRAIN : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_out_xfer) begin
                        r_in_left  <= r_in_left - c_CNT_W'(1);
                        r_out_left <= r_out_left - c_CNT_W'(1);
                        if (r_out_left == c_CNT_W'(1)) begin
                            r_state <= ST_IDLE;
                        end else if (w_in_last_exp) begin
                            // Inputs exhausted with one beat still held.
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (log_ctrl_realign_rd_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Hold register needs no reset: it is always written before it is read.
    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_hold <= src_realign_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prepare_eng_log_realign.sv
`default_nettype none
// ============================================================================
// Module   : tb_prepare_eng_log_realign
// Purpose  : Self-checking bench for prepare_eng_log_realign (B = 64).
//            Expected beats come from a byte-stream model: input words are
//            flattened to bytes, the header is dropped, and the payload is
//            cut into B-byte beats.
// Config   : PREP_REALIGN_ZERO_PAD_EN - pad bytes are also checked as zero
// Revision : 1.0 - initial release
// ============================================================================
module tb_prepare_eng_log_realign;

    localparam int DW  = 512;
    localparam int LW  = 16;
    localparam int B   = DW / 8;
    localparam int SW  = $clog2(B);

    logic          clk;
    logic          rst_n;
    logic          cmd_val;
    logic [SW-1:0] cmd_shift;
    logic [LW-1:0] cmd_len;
    logic          cmd_rdy;
    logic          data_val;
    logic [DW-1:0] data;
    logic          data_last;
    logic          data_rdy;
    logic          rd_val;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [SW-1:0] rd_pad;
    logic          rd_rdy;
    logic          len_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_err = 1'b0;

    prepare_eng_log_realign #(
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .src_realign_cmd_val          (cmd_val),
        .src_realign_cmd_shift        (cmd_shift),
        .src_realign_cmd_len          (cmd_len),
        .realign_src_cmd_rdy          (cmd_rdy),
        .src_realign_data_val         (data_val),
        .src_realign_data             (data),
        .src_realign_data_last        (data_last),
        .realign_src_data_rdy         (data_rdy),
        .realign_log_ctrl_rd_val      (rd_val),
        .realign_log_ctrl_rd_data     (rd_data),
        .realign_log_ctrl_rd_last     (rd_last),
        .realign_log_ctrl_rd_padbytes (rd_pad),
        .log_ctrl_realign_rd_rdy      (rd_rdy),
        .realign_len_err              (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One request: cmd (sh, len), inputs supplied as fast as accepted.
    // mode: 0 rd_rdy always 1, 1 toggling, 2 random.
    // err_word: index of input word whose last flag is inverted (-1 none).
    // abort_after: return right after this many beats (-1 run to completion).
    task automatic run_req(input int sh, input int len, input int mode,
                           input int err_word, input int abort_after);
        logic [DW-1:0] in_w[$];
        logic [DW-1:0] exp_w[$];
        int            exp_nvalid[$];
        logic [7:0]    flat[$];
        logic [DW-1:0] w;
        logic [DW-1:0] mask;
        int nin, nout, in_idx, beat, cyc, first_acc;
        logic in_acc, out_x;

        nin  = (len + sh + B - 1) / B;
        nout = (len + B - 1) / B;
        for (int i = 0; i < nin; i++) begin
            for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom();
            in_w.push_back(w);
            for (int b = 0; b < B; b++) flat.push_back(w[DW-1-8*b -: 8]);
        end
        for (int k = 0; k < nout; k++) begin
            w = '0;
            for (int b = 0; b < B; b++)
                if (k * B + b < len) w[DW-1-8*b -: 8] = flat[sh + k * B + b];
            exp_w.push_back(w);
            exp_nvalid.push_back((len - k * B) < B ? (len - k * B) : B);
        end

        @(negedge clk);
        cmd_val   = 1'b1;
        cmd_shift = SW'(sh);
        cmd_len   = LW'(len);
        #1;
        chk("cmd_rdy_idle", DW'(cmd_rdy), DW'(1));

        in_idx = 0; beat = 0; cyc = 0; first_acc = -1;
        while (beat < nout && cyc < 400) begin
            @(negedge clk);
            cmd_val   = 1'b0;
            data_val  = (in_idx < nin);
            data      = (in_idx < nin) ? in_w[in_idx] : '0;
            data_last = (in_idx == nin - 1) ^ (in_idx == err_word);
            rd_rdy    = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            #1;
            in_acc = data_val && data_rdy;
            out_x  = rd_val && rd_rdy;
            chk("len_err", DW'(len_err), DW'(exp_err));
            if (in_acc && first_acc < 0) begin
                first_acc = cyc;
                if (mode == 0) chk("first_in_latency", DW'(cyc), DW'(sh == 0 ? 1 : 0));
            end
            if (out_x) begin
                mask = '0;
                for (int b = 0; b < B; b++)
                    if (b < exp_nvalid[beat]) mask[DW-1-8*b -: 8] = 8'hFF;
`ifdef PREP_REALIGN_ZERO_PAD_EN
                mask = '1;
`endif
                chk("beat_data", rd_data & mask, exp_w[beat] & mask);
                chk("beat_last", DW'(rd_last), DW'(beat == nout - 1));
                chk("beat_pad", DW'(rd_pad), DW'(beat == nout - 1 ? nout * B - len : 0));
                // Shifted: input k+1 rides with beat k; a drain beat has none.
                chk("lockstep", DW'(in_acc), DW'(sh == 0 ? 1 : (beat < nin - 1 ? 1 : 0)));
                beat++;
            end else if (in_acc) begin
                // Only the priming word may be taken without a beat.
                chk("prime_only", DW'(sh == 0 ? -1 : in_idx), DW'(0));
            end
            if (in_acc) begin
                if (data_last != (in_idx == nin - 1)) exp_err = 1'b1;
                in_idx++;
            end
            cyc++;
            if (abort_after >= 0 && beat == abort_after) return;
        end
        chk("req_done", DW'(beat), DW'(nout));

        @(negedge clk);
        data_val = 1'b0;
        rd_rdy   = 1'b1;
        #1;
        chk("inputs_consumed", DW'(in_idx), DW'(nin));
        chk("back_to_back_rdy", DW'(cmd_rdy), DW'(1));
        chk("idle_no_val", DW'(rd_val), DW'(0));
    endtask

    initial begin
        rst_n = 1'b0; cmd_val = 1'b0; cmd_shift = '0; cmd_len = '0;
        data_val = 1'b0; data = '0; data_last = 1'b0; rd_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_rdy", DW'(cmd_rdy), DW'(1));
        chk("rst_rd_val", DW'(rd_val), DW'(0));
        chk("rst_rd_last", DW'(rd_last), DW'(0));
        chk("rst_rd_pad", DW'(rd_pad), DW'(0));
        chk("rst_data_rdy", DW'(data_rdy), DW'(0));
        chk("rst_len_err", DW'(len_err), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_req(0, 128, 0, -1, -1);   // pass-through
        run_req(10, 100, 0, -1, -1);  // shifted with drain
        run_req(40, 60, 0, -1, -1);   // shifted, no drain
        run_req(10, 100, 1, -1, -1);  // backpressure

        // Zero-length command is dropped.
        @(negedge clk);
        cmd_val = 1'b1; cmd_shift = SW'(5); cmd_len = '0; data_val = 1'b1;
        @(negedge clk);
        cmd_val = 1'b0;
        #1;
        chk("len0_cmd_rdy", DW'(cmd_rdy), DW'(1));
        chk("len0_data_rdy", DW'(data_rdy), DW'(0));
        chk("len0_rd_val", DW'(rd_val), DW'(0));
        data_val = 1'b0;

        for (int r = 0; r < 8; r++)
            run_req(int'($urandom_range(0, B - 1)), int'($urandom_range(1, 300)),
                    int'($urandom_range(0, 2)), -1, -1);
        run_req(0, 1, 2, -1, -1);
        run_req(63, 1, 0, -1, -1);

        // Length error: last flagged on word 0; request still completes.
        run_req(10, 100, 0, 0, -1);
        chk("len_err_sticky", DW'(len_err), DW'(1));

        // Reset after the first beat of a drain-type request.
        run_req(10, 100, 0, -1, 1);
        rst_n = 1'b0;
        data_val = 1'b0;
        rd_rdy = 1'b1;
        exp_err = 1'b0;
        #1;
        chk("mid_rst_rd_val", DW'(rd_val), DW'(0));
        chk("mid_rst_len_err", DW'(len_err), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_rdy", DW'(cmd_rdy), DW'(1));
        chk("post_rst_rd_val", DW'(rd_val), DW'(0));
        run_req(0, 64, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
